// File: rtl/intr_vec.sv
// Vectored interrupt controller: per-source sticky pending with edge/level mode,
// enable mask, global enable and a fixed-priority claim register (source 0 wins).

module intr_vec_src (
  input  logic clk,
  input  logic reset,
  input  logic src_i,
  input  logic mode_i,
  input  logic clr_i,
  output logic src_q_o,
  output logic pend_q_o
);
  logic src_q, pend_q, pend_d;

  // Level sources follow the line; edge sources are sticky and set beats clear.
  always_comb begin
    if (mode_i) pend_d = (src_i & ~src_q) | (pend_q & ~clr_i);
    else        pend_d = src_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      src_q  <= src_i;
      pend_q <= pend_d;
    end
  end

  assign src_q_o  = src_q;
  assign pend_q_o = pend_q;
endmodule

module intr_vec #(
  parameter int RV   = 16,
  parameter int NSRC = 8,
  parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [3:0]      io_addr,
  input  logic            io_write,
  input  logic            io_read,
  input  logic [RV-1:0]   io_wdata,
  output logic [RV-1:0]   io_rdata,
  output logic            interrupt
);
  typedef struct packed {
    logic pend_w;
    logic en_w;
    logic mode_w;
    logic ctrl_w;
    logic claim_r;
  } acc_t;

  acc_t            acc;
  logic [NSRC-1:0] src_q, pend_q, clr, act, win_oh;
  logic [NSRC-1:0] en_q, en_d, mode_q, mode_d;
  logic            gie_q, gie_d, irq_q, irq_d;
  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic            unused_wdata;

  assign acc.pend_w  = io_write & (io_addr == 4'd0);
  assign acc.en_w    = io_write & (io_addr == 4'd1);
  assign acc.mode_w  = io_write & (io_addr == 4'd2);
  assign acc.ctrl_w  = io_write & (io_addr == 4'd5);
  assign acc.claim_r = io_read  & (io_addr == 4'd3);

  assign act     = pend_q & en_q;
  assign win_vld = |act;
  assign win_oh  = act & ~(act - NSRC'(1));

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NSRC; i++)
      if (win_oh[i]) win_idx = win_idx | IW'(i);
  end

  // Lanes ignore clr in level mode, so W1C and claim only affect edge sources.
  assign clr = ({NSRC{acc.pend_w}} & io_wdata[NSRC-1:0])
             | ({NSRC{acc.claim_r & win_vld}} & win_oh);

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    intr_vec_src u_src (
      .clk      (clk),
      .reset    (reset),
      .src_i    (src[g]),
      .mode_i   (mode_q[g]),
      .clr_i    (clr[g]),
      .src_q_o  (src_q[g]),
      .pend_q_o (pend_q[g])
    );
  end

  assign en_d   = acc.en_w   ? io_wdata[NSRC-1:0] : en_q;
  assign mode_d = acc.mode_w ? io_wdata[NSRC-1:0] : mode_q;
  assign gie_d  = acc.ctrl_w ? io_wdata[0]        : gie_q;
  assign irq_d  = gie_q & win_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q   <= '0;
      mode_q <= '0;
      gie_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      mode_q <= mode_d;
      gie_q  <= gie_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    io_rdata = '0;
    case (io_addr)
      4'd0: io_rdata[NSRC-1:0] = pend_q;
      4'd1: io_rdata[NSRC-1:0] = en_q;
      4'd2: io_rdata[NSRC-1:0] = mode_q;
      4'd3: begin
        io_rdata[RV-1]   = win_vld;
        io_rdata[IW-1:0] = win_idx;
      end
      4'd4: io_rdata[NSRC-1:0] = src_q;
      4'd5: io_rdata[0] = gie_q;
      default: ;
    endcase
  end

  assign interrupt    = irq_q;
  assign unused_wdata = ^io_wdata[RV-1:NSRC];
endmodule
